// File: rtl/dbus_mmio_if.sv
// CPU data-side bus between the MEM stage (master) and the data bus block (slave).
// Load data and bus error come back combinationally in the same cycle.
interface dbus_mmio_if #(
  parameter int XLEN = 32
);
  logic            mem_load;
  logic            mem_store;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;
  logic            bus_error;

  modport master (
    output mem_load, mem_store, address, store_data,
    input  load_data, bus_error
  );

  modport slave (
    input  mem_load, mem_store, address, store_data,
    output load_data, bus_error
  );
endinterface

// File: rtl/dbus_mmio.sv
// Data bus decoder: external RAM window plus an MMIO page holding a buffered
// UART transmitter and a 64-bit machine timer with compare interrupt.
module dbus_mmio #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] IO_BASE     = 32'h1000_0000,
  parameter logic [XLEN-1:0] RAM_BASE    = 32'h0000_0000,
  parameter int              RAM_AW      = 16,
  parameter int              FIFO_DEPTH  = 8,
  parameter logic [15:0]     DEFAULT_DIV = 16'd867
) (
  input  logic              clock,
  input  logic              reset,
  dbus_mmio_if.slave        bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic              uart_tx,
  output logic              timer_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  logic        ram_sel, io_sel, io_wr;
  logic [9:0]  reg_idx;
  logic [31:0] wdata;
  logic [31:0] io_rdata;

  assign reg_idx = bus.address[11:2];
  assign wdata   = bus.store_data[31:0];
  assign ram_sel = bus.address[XLEN-1:RAM_AW] == RAM_BASE[XLEN-1:RAM_AW];
  assign io_sel  = bus.address[XLEN-1:12] == IO_BASE[XLEN-1:12];
  assign io_wr   = bus.mem_store && io_sel;

  assign ram_addr      = bus.address[RAM_AW-1:0];
  assign ram_we        = bus.mem_store && ram_sel;
  assign ram_wdata     = bus.store_data;
  assign bus.bus_error = (bus.mem_load || bus.mem_store) && !ram_sel && !io_sel;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push_req, push, pop, overrun;
  logic [15:0]   div;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, frame_div_q;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q;
  logic          tx_d;

  assign full     = count == (PW + 1)'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push_req = io_wr && reg_idx == 10'h000;
  // A push against a full FIFO is dropped even if the UART pops this cycle.
  assign push     = push_req && !full;
  assign pop      = state_q == IDLE && !empty;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      div     <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full)
        overrun <= 1'b1;
      else if (io_wr && reg_idx == 10'h001 && wdata[3])
        overrun <= 1'b0;
      if (io_wr && reg_idx == 10'h002) div <= wdata[15:0];
    end
  end

  // The divider is latched per frame so a DIV write never stretches a frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_div_q <= '0;
      uart_tx     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      uart_tx <= tx_d;
      if (pop) begin
        shift_q     <= fifo_mem[rd_ptr];
        frame_div_q <= div;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          cnt_d   = div;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = frame_div_q;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = frame_div_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  logic [63:0] mtime, mtimecmp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (io_wr && reg_idx == 10'h004)
        mtime[31:0] <= wdata;
      else if (io_wr && reg_idx == 10'h005)
        mtime[63:32] <= wdata;
      else
        mtime <= mtime + 64'd1;
      if (io_wr && reg_idx == 10'h006) mtimecmp[31:0]  <= wdata;
      if (io_wr && reg_idx == 10'h007) mtimecmp[63:32] <= wdata;
    end
  end

  assign timer_irq = mtime >= mtimecmp;

  always_comb begin
    io_rdata = '0;
    case (reg_idx)
      10'h001: io_rdata = {16'b0, 8'(count), 4'b0, overrun, state_q != IDLE, empty, full};
      10'h002: io_rdata = {16'b0, div};
      10'h004: io_rdata = mtime[31:0];
      10'h005: io_rdata = mtime[63:32];
      10'h006: io_rdata = mtimecmp[31:0];
      10'h007: io_rdata = mtimecmp[63:32];
      default: io_rdata = '0;
    endcase
  end

  assign bus.load_data = ram_sel ? ram_rdata :
                         io_sel  ? XLEN'(io_rdata) : '0;

endmodule
